simon_controller: RTL
=====================

Name: simon_controller

Overview:
- Game-flow controller for the Simon game; sole master of the pseudo-random sequence generator.
- Drives its randomize / start_over / next strobes and reads back its one-hot element.
- Plays the first N elements on the LEDs, then checks the player's button presses against the same elements, growing N by one per cleared round.
- Sits between the debounced button front end and the LED/score display.

Parameters:
- ON_TICKS, 50_000_000: clk cycles an element's LED is lit during playback.
- OFF_TICKS, 25_000_000: dark gap after each lit element, and the pause before playback starts.
- TIMEOUT_TICKS, 250_000_000: max clk cycles allowed between player presses.
- MAX_ROUND, 16: round length that wins the game (1..31).
- TW, 28: timer width; must hold max(ON_TICKS, OFF_TICKS, TIMEOUT_TICKS).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse, new game
- btn  in  4  player buttons, debounced, single-cycle pulses
- seq  in  4  one-hot current element from generator
- seq_randomize  out  1  generator: latch new seed
- seq_start_over  out  1  generator: rewind to seed
- seq_next  out  1  generator: advance one element
- led  out  4  one-hot LED drive
- round  out  5  current round length N (0 in IDLE)
- player_turn  out  1  high while awaiting player input
- win  out  1  level, game won
- lose  out  1  level, game lost

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all strobes 0, led=0, round=0, player_turn=0, win=0, lose=0.
  - Timer and index counters cleared.
  - Reset mid-game aborts immediately; no strobe may be asserted during reset.
- Strobe rules:
  - All strobes are registered, exactly one cycle wide, and mutually exclusive.
  - The generator updates on the edge that samples a strobe, so seq is valid the cycle after. The controller never samples seq in the cycle a strobe is high.
- FSM states and transitions:
  - IDLE: led=0. start -> pulse seq_randomize, round<=1, go PRE_GAP.
  - PRE_GAP: wait OFF_TICKS, then pulse seq_start_over, idx<=0, go SETTLE_S.
  - SETTLE_S: one cycle, go SHOW_ON.
  - SHOW_ON: led=seq for ON_TICKS, then go SHOW_OFF.
  - SHOW_OFF: led=0 for OFF_TICKS. Then if idx==round-1: pulse seq_start_over, idx<=0, go SETTLE_P. Else pulse seq_next, idx++, go SETTLE_S.
  - SETTLE_P: one cycle, go WAIT_IN. Timer is loaded with TIMEOUT_TICKS on entry to WAIT_IN.
  - WAIT_IN: player_turn=1, led=btn (echo).
    - btn==0: timer counts down; reaching 0 -> LOSE.
    - btn==seq and idx<round-1: pulse seq_next, idx++, reload timer, go SETTLE_P.
    - btn==seq and idx==round-1: if round==MAX_ROUND go WIN; else round++, go PRE_GAP.
    - btn!=seq, including multi-hot: go LOSE.
  - WIN / LOSE: win or lose held at 1. led blinks all-on/all-off (WIN) or seq (LOSE), toggling every ON_TICKS. start -> clear win/lose, same action as from IDLE.
- Input gating:
  - start is ignored in every state except IDLE, WIN and LOSE.
  - btn is ignored outside WAIT_IN.
  - start and btn in the same cycle in WAIT_IN: start ignored, btn processed.
- Counters:
  - Timer is a TW-bit down-counter. Loading with K yields exactly K cycles in the state.
  - idx is 5 bits and never exceeds round-1. round saturates at MAX_ROUND.

Decomposition:
- Package simon_pkg holds:
  - state enum (IDLE, PRE_GAP, SETTLE_S, SHOW_ON, SHOW_OFF, SETTLE_P, WAIT_IN, WIN, LOSE);
  - one-hot colour constants;
  - default tick constants.
- One sub-module, simon_timer: loadable TW-bit down-counter with a load input and a done flag.
- The controller instantiates no generator; it connects to one at the top level.

Test Plan (bench uses ON_TICKS=4, OFF_TICKS=2, TIMEOUT_TICKS=20, MAX_ROUND=3, and a real generator):
- Reset then start: seq_randomize high exactly 1 cycle after start; after 2 gap cycles seq_start_over pulses; led equals the generator's first element for exactly 4 cycles; then player_turn=1 with round=1.
- Correct press in round 1: round becomes 2; playback shows element0 then element1 with exactly one seq_next pulse between them, and each element's led is lit for exactly 4 cycles.
- Complete 3 rounds correctly: win=1 after the third correct press of round 3; led blinks with period 8; start clears win and pulses seq_randomize.
- Wrong button (btn=~seq&4'hF one-hot variant) in round 2, second element: lose=1 next cycle; round stays 2; no seq_next issued.
- No press for 20 cycles in WAIT_IN: lose=1 on cycle 20; btn=4'b0011 multi-hot in a fresh game: immediate lose.
- Assert rst_n=0 mid SHOW_ON: led=0, round=0 and all strobes 0 immediately; start pressed during SHOW_ON or btn during playback is ignored, with no state change.

Source files
------------

// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon game controller.
// Holds the FSM state enum, the one-hot colours and the default tick counts.
package simon_pkg;

  typedef enum logic [3:0] {
    IDLE, PRE_GAP, SETTLE_S, SHOW_ON, SHOW_OFF, SETTLE_P, WAIT_IN, WIN, LOSE
  } state_e;

  localparam logic [3:0] COL_NONE   = 4'b0000;
  localparam logic [3:0] COL_RED    = 4'b0001;
  localparam logic [3:0] COL_GREEN  = 4'b0010;
  localparam logic [3:0] COL_BLUE   = 4'b0100;
  localparam logic [3:0] COL_YELLOW = 4'b1000;
  localparam logic [3:0] COL_ALL    = 4'b1111;

  localparam int DEF_ON_TICKS      = 50_000_000;
  localparam int DEF_OFF_TICKS     = 25_000_000;
  localparam int DEF_TIMEOUT_TICKS = 250_000_000;
  localparam int DEF_MAX_ROUND     = 16;
  localparam int DEF_TW            = 28;

  // Maps a 2-bit colour code onto its one-hot LED/button pattern.
  function automatic logic [3:0] colour(input logic [1:0] c);
    case (c)
      2'd0:    colour = COL_RED;
      2'd1:    colour = COL_GREEN;
      2'd2:    colour = COL_BLUE;
      default: colour = COL_YELLOW;
    endcase
  endfunction

endpackage

// File: rtl/simon_timer.sv
// Loadable down-counter: a load of K keeps done_o low for K-1 cycles and
// raises it on the K-th, so the owning state lasts exactly K cycles.
module simon_timer #(
  parameter int TW = 28
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic [TW-1:0] load_val_i,
  output logic          done_o
);

  logic [TW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             cnt_q <= '0;
    else if (load_i)        cnt_q <= load_val_i;
    else if (cnt_q != '0)   cnt_q <= cnt_q - TW'(1);
  end

  assign done_o = (cnt_q <= TW'(1));

endmodule

// File: rtl/simon_controller.sv
// Simon game-flow FSM: drives the sequence generator strobes, plays the
// sequence on the LEDs and checks the player's presses round by round.
module simon_controller
  import simon_pkg::*;
#(
  parameter int ON_TICKS      = DEF_ON_TICKS,
  parameter int OFF_TICKS     = DEF_OFF_TICKS,
  parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS,
  parameter int MAX_ROUND     = DEF_MAX_ROUND,
  parameter int TW            = DEF_TW
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] btn,
  input  logic [3:0] seq,
  output logic       seq_randomize,
  output logic       seq_start_over,
  output logic       seq_next,
  output logic [3:0] led,
  output logic [4:0] round,
  output logic       player_turn,
  output logic       win,
  output logic       lose
);

  localparam logic [TW-1:0] ON_T  = TW'(ON_TICKS);
  localparam logic [TW-1:0] OFF_T = TW'(OFF_TICKS);
  localparam logic [TW-1:0] TO_T  = TW'(TIMEOUT_TICKS);
  localparam logic [4:0]    MAX_R = 5'(MAX_ROUND);

  state_e        state_q, state_d;
  logic [4:0]    idx_q, idx_d, round_q, round_d;
  logic          blink_q, blink_d;
  logic          rand_q, rand_d, so_q, so_d, nx_q, nx_d;
  logic          tmr_load, tmr_done;
  logic [TW-1:0] tmr_val;
  logic          last_elem, hit;

  simon_timer #(.TW(TW)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .done_o    (tmr_done)
  );

  assign last_elem = (idx_q == round_q - 5'd1);
  assign hit       = (btn == seq) && (btn != COL_NONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      round_q <= '0;
      blink_q <= 1'b0;
      rand_q  <= 1'b0;
      so_q    <= 1'b0;
      nx_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      round_q <= round_d;
      blink_q <= blink_d;
      rand_q  <= rand_d;
      so_q    <= so_d;
      nx_q    <= nx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    round_d  = round_q;
    blink_d  = blink_q;
    rand_d   = 1'b0;
    so_d     = 1'b0;
    nx_d     = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = ON_T;
    case (state_q)
      IDLE, WIN, LOSE: begin
        if (state_q != IDLE && tmr_done) begin
          tmr_load = 1'b1;
          blink_d  = ~blink_q;
        end
        if (start) begin
          rand_d   = 1'b1;
          round_d  = 5'd1;
          idx_d    = '0;
          tmr_load = 1'b1;
          tmr_val  = OFF_T;
          state_d  = PRE_GAP;
        end
      end
      PRE_GAP: if (tmr_done) begin
        so_d    = 1'b1;
        idx_d   = '0;
        state_d = SETTLE_S;
      end
      SETTLE_S: begin
        tmr_load = 1'b1;
        state_d  = SHOW_ON;
      end
      SHOW_ON: if (tmr_done) begin
        tmr_load = 1'b1;
        tmr_val  = OFF_T;
        state_d  = SHOW_OFF;
      end
      SHOW_OFF: if (tmr_done) begin
        if (last_elem) begin
          so_d    = 1'b1;
          idx_d   = '0;
          state_d = SETTLE_P;
        end else begin
          nx_d    = 1'b1;
          idx_d   = idx_q + 5'd1;
          state_d = SETTLE_S;
        end
      end
      SETTLE_P: begin
        tmr_load = 1'b1;
        tmr_val  = TO_T;
        state_d  = WAIT_IN;
      end
      WAIT_IN: begin
        // Any press decides this cycle; the timeout only matters when idle.
        if (btn != COL_NONE) begin
          tmr_load = 1'b1;
          if (!hit) begin
            blink_d = 1'b1;
            state_d = LOSE;
          end else if (!last_elem) begin
            nx_d    = 1'b1;
            idx_d   = idx_q + 5'd1;
            tmr_val = TO_T;
            state_d = SETTLE_P;
          end else if (round_q >= MAX_R) begin
            blink_d = 1'b1;
            state_d = WIN;
          end else begin
            round_d = round_q + 5'd1;
            tmr_val = OFF_T;
            state_d = PRE_GAP;
          end
        end else if (tmr_done) begin
          tmr_load = 1'b1;
          blink_d  = 1'b1;
          state_d  = LOSE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    led = COL_NONE;
    case (state_q)
      SHOW_ON: led = seq;
      WAIT_IN: led = btn;
      WIN:     led = blink_q ? COL_ALL : COL_NONE;
      LOSE:    led = blink_q ? seq : COL_NONE;
      default: led = COL_NONE;
    endcase
  end

  assign player_turn    = (state_q == WAIT_IN);
  assign win            = (state_q == WIN);
  assign lose           = (state_q == LOSE);
  assign round          = round_q;
  assign seq_randomize  = rand_q;
  assign seq_start_over = so_q;
  assign seq_next       = nx_q;

endmodule
